// File: rtl/daisy_chain_irq_ctrl.sv
// daisy_chain_irq_ctrl
//   Clocked daisy-chain interrupt priority block. It latches falling-edge
//   requests on N_CH local lines and presents one active-low interrupt to the
//   CPU. On an acknowledge falling edge it either grants the highest-priority
//   eligible channel (channel 0 is highest) and returns its vector, or, when
//   nothing is requested locally, forwards the acknowledge downstream.
//   The granted channel stays in service until an end-of-interrupt pulse.
//
// Ports
//   clk        in   1      system clock, rising edge
//   rst        in   1      synchronous active-high reset
//   irq_n      in   N_CH   active-low request lines, falling-edge triggered
//   mask       in   N_CH   1 = channel excluded from arbitration
//   ack_n_in   in   1      active-low acknowledge from CPU / upstream block
//   eoi        in   1      end-of-interrupt pulse
//   int_n      out  1      active-low interrupt to CPU (registered)
//   ack_out_n  out  1      active-low acknowledge to downstream block
//   vec        out  VEC_W  vector of the granted channel
//   vec_valid  out  1      one-cycle pulse marking a new grant
//   busy       out  1      a channel is in service
module daisy_chain_irq_ctrl #(
    parameter int              N_CH     = 4,
    parameter int              VEC_W    = 8,
    parameter logic [VEC_W-1:0] VEC_BASE = 8'h20
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [N_CH-1:0]   irq_n,
    input  logic [N_CH-1:0]   mask,
    input  logic              ack_n_in,
    input  logic              eoi,
    output logic              int_n,
    output logic              ack_out_n,
    output logic [VEC_W-1:0]  vec,
    output logic              vec_valid,
    output logic              busy
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        SERVICE = 2'd2
    } state_t;

    state_t            state, state_nxt;
    logic [N_CH-1:0]   pending;
    logic [N_CH-1:0]   irq_prev;
    logic              ack_prev;

    logic [N_CH-1:0]   fall;
    logic [N_CH-1:0]   elig;
    logic [N_CH-1:0]   gnt_oh;
    logic [5:0]        gnt_idx;
    logic              ack_fall;
    logic              grant;

    // Vector arithmetic wraps modulo 2^VEC_W.
    function automatic logic [VEC_W-1:0] vec_of(input logic [5:0] idx);
        return VEC_BASE + VEC_W'(idx);
    endfunction

    assign fall     = irq_prev & ~irq_n;
    assign elig     = pending & ~mask;
    assign ack_fall = ack_prev & ~ack_n_in;
    // Isolate the lowest set bit: that is the highest-priority winner.
    assign gnt_oh   = elig & (~elig + 1'b1);

    always_comb begin
        gnt_idx = '0;
        for (int i = N_CH - 1; i >= 0; i--) begin
            if (elig[i]) gnt_idx = 6'(i);
        end
    end

    always_comb begin
        state_nxt = state;
        grant     = 1'b0;
        case (state)
            IDLE: begin
                if (|elig) state_nxt = REQ;
            end
            REQ: begin
                // Losing eligibility takes priority over a coincident ack,
                // which is then simply forwarded downstream.
                if (!(|elig)) begin
                    state_nxt = IDLE;
                end else if (ack_fall) begin
                    grant     = 1'b1;
                    state_nxt = SERVICE;
                end
            end
            SERVICE: begin
                if (eoi) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            pending   <= '0;
            irq_prev  <= '1;
            ack_prev  <= 1'b1;
            int_n     <= 1'b1;
            ack_out_n <= 1'b1;
            vec       <= '0;
            vec_valid <= 1'b0;
            busy      <= 1'b0;
        end else begin
            state     <= state_nxt;
            irq_prev  <= irq_n;
            ack_prev  <= ack_n_in;
            // A new edge on the channel being cleared still wins.
            pending   <= (pending & ~(grant ? gnt_oh : '0)) | fall;
            // int_n is asserted only after a full cycle in REQ, giving the
            // two-edge request-to-interrupt latency.
            int_n     <= !(state == REQ && state_nxt == REQ);
            ack_out_n <= grant ? 1'b1 : ack_n_in;
            vec_valid <= grant;
            busy      <= (state_nxt == SERVICE);
            if (grant) vec <= vec_of(gnt_idx);
        end
    end

endmodule

// File: tb/tb_daisy_chain_irq_ctrl.sv
module tb_daisy_chain_irq_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] irq_n;
    logic [3:0] mask;
    logic       ack_n_in;
    logic       eoi;

    logic       int_n_a, ack_out_n_a, vec_valid_a, busy_a;
    logic [7:0] vec_a;
    logic       int_n_b, ack_out_n_b, vec_valid_b, busy_b;
    logic [7:0] vec_b;

    int total = 0;
    int bad   = 0;

    logic [7:0] exp_q_a[$];
    logic [7:0] exp_q_b[$];

    always #5 clk = ~clk;

    daisy_chain_irq_ctrl #(.N_CH(4), .VEC_W(8), .VEC_BASE(8'h20)) u_dut_a (
        .clk(clk), .rst(rst), .irq_n(irq_n), .mask(mask),
        .ack_n_in(ack_n_in), .eoi(eoi),
        .int_n(int_n_a), .ack_out_n(ack_out_n_a), .vec(vec_a),
        .vec_valid(vec_valid_a), .busy(busy_a)
    );

    // Same stimulus, base near the top of the range to exercise vector wrap.
    daisy_chain_irq_ctrl #(.N_CH(4), .VEC_W(8), .VEC_BASE(8'hFE)) u_dut_b (
        .clk(clk), .rst(rst), .irq_n(irq_n), .mask(mask),
        .ack_n_in(ack_n_in), .eoi(eoi),
        .int_n(int_n_b), .ack_out_n(ack_out_n_b), .vec(vec_b),
        .vec_valid(vec_valid_b), .busy(busy_b)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    // Scoreboard: each vec_valid pulse must match the oldest queued grant.
    always @(negedge clk) begin
        if (vec_valid_a === 1'b1) begin
            if (exp_q_a.size() == 0) chk("vec_a_unexpected", 1, 0);
            else chk("vec_a", {24'd0, vec_a}, {24'd0, exp_q_a.pop_front()});
        end
        if (vec_valid_b === 1'b1) begin
            if (exp_q_b.size() == 0) chk("vec_b_unexpected", 1, 0);
            else chk("vec_b", {24'd0, vec_b}, {24'd0, exp_q_b.pop_front()});
        end
    end

    task automatic do_grant(input logic [7:0] ea, input logic [7:0] eb);
        exp_q_a.push_back(ea);
        exp_q_b.push_back(eb);
        ack_n_in = 1'b0;
        tick();
        chk("grant_busy", busy_a, 1);
        chk("grant_int_n", int_n_a, 1);
        chk("grant_ack_out", ack_out_n_a, 1);
        ack_n_in = 1'b1;
        tick();
        chk("vv_once", vec_valid_a, 0);
        chk("ack_out_held", ack_out_n_a, 1);
        chk("svc_busy", busy_b, 1);
    endtask

    task automatic do_eoi();
        eoi = 1'b1;
        tick();
        eoi = 1'b0;
        chk("eoi_busy", busy_a, 0);
    endtask

    initial begin
        rst      = 1'b1;
        irq_n    = 4'hF;
        mask     = 4'h0;
        ack_n_in = 1'b1;
        eoi      = 1'b0;

        // 1: reset state
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("rst_int_n", int_n_a, 1);
            chk("rst_ack_out", ack_out_n_a, 1);
            chk("rst_vv", vec_valid_a, 0);
            chk("rst_busy", busy_a, 0);
            chk("rst_vec", {24'd0, vec_a}, 0);
        end
        rst = 1'b0;
        tick();

        // 2: single request on channel 2
        irq_n[2] = 1'b0;
        tick();
        chk("t2_int_t0", int_n_a, 1);
        tick();
        chk("t2_int_t1", int_n_a, 1);
        tick();
        chk("t2_int_t2", int_n_a, 0);
        do_grant(8'h22, 8'h00);
        irq_n[2] = 1'b1;
        do_eoi();
        tick();
        chk("t2_idle_int", int_n_a, 1);

        // 3: simultaneous requests on channels 3 and 1
        irq_n[3] = 1'b0;
        irq_n[1] = 1'b0;
        repeat (3) tick();
        chk("t3_int", int_n_a, 0);
        do_grant(8'h21, 8'hFF);
        do_eoi();
        tick();
        chk("t3_reassert_early", int_n_a, 1);
        tick();
        chk("t3_reassert", int_n_a, 0);
        do_grant(8'h23, 8'h01);
        irq_n[3] = 1'b1;
        irq_n[1] = 1'b1;
        do_eoi();
        tick();

        // 4: ack forwarding with nothing pending
        ack_n_in = 1'b0;
        chk("t4_ack_pre", ack_out_n_a, 1);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("t4_ack_fwd", ack_out_n_a, 0);
            chk("t4_vv", vec_valid_a, 0);
        end
        ack_n_in = 1'b1;
        tick();
        chk("t4_ack_rel", ack_out_n_a, 1);
        chk("t4_busy", busy_a, 0);

        // 5: masking
        mask[0]  = 1'b1;
        irq_n[0] = 1'b0;
        repeat (4) tick();
        chk("t5_masked", int_n_a, 1);
        mask[0] = 1'b0;
        tick();
        chk("t5_unmask_1", int_n_a, 1);
        tick();
        chk("t5_unmask_2", int_n_a, 0);
        mask[0] = 1'b1;
        tick();
        chk("t5_remask", int_n_a, 1);
        mask[0] = 1'b0;
        repeat (2) tick();
        chk("t5_again", int_n_a, 0);
        do_grant(8'h20, 8'hFE);
        irq_n[0] = 1'b1;
        do_eoi();
        tick();

        // 6: reset while in service, line held low across reset
        irq_n[1] = 1'b0;
        repeat (3) tick();
        chk("t6_int", int_n_a, 0);
        do_grant(8'h21, 8'hFF);
        rst = 1'b1;
        tick();
        chk("t6_rst_busy", busy_a, 0);
        chk("t6_rst_int", int_n_a, 1);
        chk("t6_rst_vec", {24'd0, vec_a}, 0);
        rst = 1'b0;
        tick();
        tick();
        chk("t6_recap_early", int_n_a, 1);
        tick();
        chk("t6_recap", int_n_a, 0);
        do_grant(8'h21, 8'hFF);
        irq_n[1] = 1'b1;
        do_eoi();
        repeat (3) tick();
        chk("idle_int_end", int_n_a, 1);

        chk("q_a_drained", exp_q_a.size(), 0);
        chk("q_b_drained", exp_q_b.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
